// File: rtl/ps2host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2host_tx
//  Purpose  : Host-to-device PS/2 transmitter. Inhibits the bus, issues a
//             start bit, shifts one byte plus odd parity and stop on the
//             device-generated clock, then checks the device ACK. Drives the
//             open-drain lines through active-high pull-low enables.
//  Revision : 1.0  initial release
// ============================================================================
module ps2host_tx #(
  parameter int INHIBIT_CYCLES = 2000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int c_CNT_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
    S_WAITREL = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_clksr;
  logic [1:0]           r_datasr;
  logic [9:0]           r_frame;
  logic [9:0]           w_frame_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_count_nxt;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_TMR_W-1:0]   w_timer_nxt;
  logic [3:0]           r_bitcnt;
  logic [3:0]           w_bitcnt_nxt;
  logic                 r_clk_oe;
  logic                 w_clk_oe_nxt;
  logic                 r_data_oe;
  logic                 w_data_oe_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_err;
  logic                 w_err_nxt;
  logic                 w_fall;
  logic                 w_timeout;
  logic                 w_fail;

  // Falling edge of the device clock: previous sample high, newest sample low.
  assign w_fall    = (r_clksr == 2'b10);
  assign w_timeout = (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));

  // Two-stage input shift registers for the raw bus lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clksr  <= 2'b11;
      r_datasr <= 2'b11;
    end else begin
      r_clksr  <= {r_clksr[0], ps2_clk};
      r_datasr <= {r_datasr[0], ps2_data};
    end
  end

  // State register and all registered datapath/outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_count   <= '0;
      r_timer   <= '0;
      r_bitcnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_count   <= w_count_nxt;
      r_timer   <= w_timer_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state, frame shifting, timeout and ACK evaluation.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_count_nxt   = r_count;
    w_timer_nxt   = r_timer;
    w_bitcnt_nxt  = r_bitcnt;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_fail        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_req) begin
          // Frame bits 0..7 data, 8 odd parity, 9 stop.
          w_frame_nxt  = {1'b1, ~^tx_data, tx_data};
          w_clk_oe_nxt = 1'b1;
          w_count_nxt  = '0;
          w_state_nxt  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (r_count == c_CNT_W'(INHIBIT_CYCLES - 1)) begin
          // Start bit goes low one cycle before the clock is released.
          w_data_oe_nxt = 1'b1;
          w_count_nxt   = r_count + 1'b1;
        end else if (r_count == c_CNT_W'(INHIBIT_CYCLES)) begin
          w_clk_oe_nxt = 1'b0;
          w_bitcnt_nxt = '0;
          w_timer_nxt  = '0;
          w_state_nxt  = S_START;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end

      S_START, S_DATA: begin
        w_timer_nxt = r_timer + 1'b1;
        if (w_fall) begin
          w_timer_nxt  = '0;
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == 4'd10) begin
            // Eleventh edge: device must be pulling data low as ACK.
            if (!r_datasr[1]) begin
              w_state_nxt = S_WAITREL;
            end else begin
              w_fail = 1'b1;
            end
          end else begin
            // Edges 1..10 present data, parity, then the (released) stop bit.
            w_data_oe_nxt = ~r_frame[r_bitcnt];
            w_state_nxt   = S_DATA;
          end
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
      end

      S_WAITREL: begin
        w_timer_nxt = r_timer + 1'b1;
        if (r_clksr[1] && r_datasr[1]) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_fail) begin
      w_state_nxt   = S_IDLE;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_err_nxt     = 1'b1;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2host_tx
//  Purpose  : Self-checking bench for ps2host_tx with an open-drain bus and a
//             PS/2 device model that clocks frames and returns ACK.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2host_tx;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic       clk_line, data_line;

  // Wired-AND open-drain bus.
  assign clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (clk_line),
    .ps2_data    (data_line),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Background monitor: pulse counts, inhibit/overlap lengths, invariants.
  int   done_cnt = 0, err_cnt = 0, inv_bad = 0, last_err_cyc = 0;
  int   low_run = 0, overlap_run = 0, inhibit_len = -1, overlap_len = -1;
  logic prev_done = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) begin err_cnt++; last_err_cyc = cyc; end
    if ((done && err) || (done && busy) || (err && busy) ||
        (!busy && (ps2_clk_oe || ps2_data_oe)) ||
        (done && prev_done) || (err && prev_err))
      inv_bad++;
    prev_done = done;
    prev_err  = err;
    if (ps2_clk_oe && !ps2_data_oe) low_run++;
    else if (ps2_clk_oe && ps2_data_oe) begin
      if (overlap_run == 0) inhibit_len = low_run;
      overlap_run++;
    end
    if (!(ps2_clk_oe && ps2_data_oe) && overlap_run != 0) begin
      overlap_len = overlap_run;
      overlap_run = 0;
    end
    if (!ps2_clk_oe) low_run = 0;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected line image: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  logic [10:0] exp_q[$];
  int          last_fall_cyc = 0;

  // Device model: waits for a start bit, generates n_edges clocks, samples on
  // each rising edge and optionally pulls data low for the ACK edge.
  task automatic device_frame(input int n_edges, input bit ack,
                              output logic [10:0] bits, output bit started);
    int w = 0;
    bits = '1;
    started = 1'b0;
    while (!(clk_line && !data_line) && w < INHIBIT * 4) begin tick(); w++; end
    if (!(clk_line && !data_line)) return;
    started = 1'b1;
    bits[0] = data_line;
    repeat (HALF) tick();
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && ack) begin dev_data_low = 1'b1; repeat (2) tick(); end
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (HALF) tick();
      if (e <= 10) bits[e] = data_line;
      dev_clk_low = 1'b0;
      repeat (HALF) tick();
      dev_data_low = 1'b0;
    end
  endtask

  task automatic sb_compare(input string name, input logic [10:0] got);
    logic [10:0] exp;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_frame"}, {21'd0, got}, {21'd0, exp});
    end
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while (busy && w < TIMEOUT * 3) begin tick(); w++; end
    check({name, "_finished"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic request(input logic [7:0] d);
    tx_data = d;
    tx_req  = 1'b1;
    tick();
    tx_req  = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [7:0] d;
    int         edges;
    bit         ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int d0, e0;
    logic [10:0] got;
    bit started;
    d0 = done_cnt;
    e0 = err_cnt;
    request(v.d);
    if (v.edges >= 10) exp_q.push_back(frame_of(v.d));
    check({v.name, "_busy"}, {31'd0, busy}, 32'd1);
    device_frame(v.edges, v.ack, got, started);
    check({v.name, "_start"}, {31'd0, started}, 32'd1);
    if (v.edges >= 10) sb_compare(v.name, got);
    wait_idle(v.name);
    repeat (3) tick();
    check({v.name, "_done"}, done_cnt - d0, v.exp_done);
    check({v.name, "_err"}, err_cnt - e0, v.exp_err);
    check({v.name, "_inhibit"}, inhibit_len, INHIBIT);
    check({v.name, "_overlap"}, overlap_len, 1);
    check({v.name, "_oe_rel"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    // Sync register (1) + TIMEOUT timer cycles + registered pulse (1).
    if (v.edges < 11) check({v.name, "_tmo_at"}, last_err_cyc - last_fall_cyc, TIMEOUT + 2);
  endtask

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    bit          started;
    int          d0, e0;

    vt[0] = '{"ed",      8'hED, 11, 1'b1, 1, 0};
    vt[1] = '{"x02",     8'h02, 11, 1'b1, 1, 0};
    vt[2] = '{"noack_ff",8'hFF, 11, 1'b0, 0, 1};
    vt[3] = '{"tmo_ed",  8'hED,  4, 1'b1, 0, 1};
    vt[4] = '{"f4",      8'hF4, 11, 1'b1, 1, 0};
    vt[5] = '{"x80",     8'h80, 11, 1'b1, 1, 0};

    // Reset state.
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    foreach (vt[i]) run_vec(vt[i]);

    // Request while busy is ignored; request in the done cycle is accepted.
    d0 = done_cnt;
    e0 = err_cnt;
    request(8'hED);
    exp_q.push_back(frame_of(8'hED));
    repeat (5) tick();
    request(8'hF4);
    repeat (3) tick();
    request(8'hF4);
    device_frame(11, 1'b1, got, started);
    sb_compare("busy_ign", got);
    wait_idle("busy_ign");
    check("done_cycle_pulse", {31'd0, done}, 32'd1);
    request(8'hF4);
    check("req_in_done_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(frame_of(8'hF4));
    device_frame(11, 1'b1, got, started);
    sb_compare("after_done", got);
    wait_idle("after_done");
    repeat (3) tick();
    check("back2back_done", done_cnt - d0, 32'd2);
    check("back2back_err", err_cnt - e0, 32'd0);

    // Asynchronous reset while the device holds clock low on edge 6.
    d0 = done_cnt;
    e0 = err_cnt;
    request(8'hC3);
    device_frame(5, 1'b1, got, started);
    dev_clk_low = 1'b1;
    repeat (3) tick();
    check("pre_rst_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("arst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    dev_clk_low = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    check("arst_no_done", done_cnt - d0, 32'd0);
    check("arst_no_err", err_cnt - e0, 32'd0);
    run_vec('{"post_rst", 8'h5A, 11, 1'b1, 1, 0});

    check("invariants", inv_bad, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
